// File: rtl/modsq_iter_ctrl_if.sv
// Handshake/data bundle between the iteration controller and its environment
// (command source, modular squarer, result consumer).
// Ports: slave = controller side, master = environment side.
interface modsq_iter_ctrl_if #(
    parameter int NUM_ELEMENTS = 21,
    parameter int BIT_LEN      = 51,
    parameter int WORD_LEN     = 50,
    parameter int ITER_W       = 64
) ();
    // command channel
    logic                                 cmd_valid;
    logic                                 cmd_ready;
    logic [ITER_W-1:0]                    cmd_iters;
    logic                                 abort;
    // squarer side
    logic                                 sq_start;
    logic                                 sq_valid;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] sq_result;
    // status
    logic [ITER_W-1:0]                    iter_count;
    logic                                 busy;
    // result stream
    logic                                 res_valid;
    logic                                 res_ready;
    logic [WORD_LEN-1:0]                  res_word;
    logic                                 res_last;
    logic [1:0]                           res_carry;

    modport slave (
        input  cmd_valid, cmd_iters, abort, sq_valid, sq_result, res_ready,
        output cmd_ready, sq_start, iter_count, busy,
               res_valid, res_word, res_last, res_carry
    );

    modport master (
        output cmd_valid, cmd_iters, abort, sq_valid, sq_result, res_ready,
        input  cmd_ready, sq_start, iter_count, busy,
               res_valid, res_word, res_last, res_carry
    );
endinterface

// File: rtl/modsq_iter_ctrl.sv
// Runs a modular squarer for a requested number of iterations, snapshots the
// redundant-digit result and streams it out as carry-normalized words.
// Ports: clk, reset (sync, active-high), bus (modsq_iter_ctrl_if.slave).
module modsq_iter_ctrl #(
    parameter int NUM_ELEMENTS = 21,
    parameter int BIT_LEN      = 51,
    parameter int WORD_LEN     = 50,
    parameter int ITER_W       = 64
) (
    input  logic             clk,
    input  logic             reset,
    modsq_iter_ctrl_if.slave bus
);
    localparam int             K_W    = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_ELEMENTS - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, OUT} state_t;

    state_t                               state;
    logic [ITER_W-1:0]                    target;
    logic [ITER_W-1:0]                    iter_count;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] snapshot;
    logic [K_W-1:0]                       k;
    logic [1:0]                           carry;
    logic                                 sq_start;
    logic                                 busy;
    logic                                 res_valid;

    logic [ITER_W-1:0]                    iter_next;
    logic [BIT_LEN:0]                     sum;
    logic                                 last_word;

    // The snapshot is shifted down one digit per transfer, so the word being
    // presented always comes from digit 0. Output data is a pure function of
    // registers and cannot change while a transfer is stalled.
    always_comb begin
        iter_next = iter_count + ITER_W'(1);
        sum       = {1'b0, snapshot[0]} + {{(BIT_LEN-1){1'b0}}, carry};
        last_word = (k == K_LAST);
    end

    assign bus.cmd_ready  = (state == IDLE) && !reset;
    assign bus.sq_start   = sq_start;
    assign bus.iter_count = iter_count;
    assign bus.busy       = busy;
    assign bus.res_valid  = res_valid;
    assign bus.res_word   = sum[WORD_LEN-1:0];
    assign bus.res_carry  = sum[WORD_LEN+1:WORD_LEN];
    assign bus.res_last   = res_valid && last_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            target     <= '0;
            iter_count <= '0;
            snapshot   <= '0;
            k          <= '0;
            carry      <= '0;
            sq_start   <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            sq_start <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is deliberately not looked at here
                    if (bus.cmd_valid) begin
                        target     <= (bus.cmd_iters == '0) ? ITER_W'(1) : bus.cmd_iters;
                        iter_count <= '0;
                        sq_start   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ARM;
                    end
                end
                ARM: begin
                    // sq_valid may still be asserted by the previous job; wait
                    // for it to drop once before trusting it.
                    if (bus.abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!bus.sq_valid) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (bus.sq_valid) begin
                        iter_count <= iter_next;
                        if (iter_next == target) begin
                            snapshot  <= bus.sq_result;
                            k         <= '0;
                            carry     <= '0;
                            res_valid <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (bus.abort) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (bus.res_ready) begin
                        if (last_word) begin
                            res_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            k        <= k + K_W'(1);
                            carry    <= sum[WORD_LEN+1:WORD_LEN];
                            snapshot <= snapshot >> BIT_LEN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
